neuron_mac: RTL

- Fixed-point single-neuron multiply-accumulate stage for the ANN datapath.
- Streams N_INPUTS (x, w) pairs of signed Q8.8 values and accumulates their products.
- Adds a bias, rescales, saturates to 16-bit signed, and presents the result with a one-cycle valid pulse.
- Sits directly upstream of the 16-bit signed holding register: out_valid drives its en, out_clr drives its clr, out_data drives its d.

---
 rtl/ann_pkg.sv | 20 ++
 rtl/ann_saturate.sv | 48 ++++
 rtl/neuron_mac.sv | 90 +++++++++
 3 files changed

// File: rtl/ann_pkg.sv
// Shared fixed-point definitions for the ANN datapath: Q8.8 format constants,
// saturation bounds, FSM state encoding and the signed data type.
package ann_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 8;
    localparam int ACC_W     = 40;

    localparam logic signed [DATA_W-1:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] Q_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        FINISH
    } state_t;

    typedef logic signed [DATA_W-1:0] data_t;

endpackage

// File: rtl/ann_saturate.sv
// Combinational accumulator-to-Q8.8 conversion: arithmetic shift, bias add,
// clamp to 16-bit signed and optional ReLU (macro NEURON_MAC_RELU_EN).
module ann_saturate
    import ann_pkg::*;
#(
    parameter int ACC_W     = 40,
    parameter int FRAC_BITS = 8
) (
    input  logic signed [ACC_W-1:0] acc,
    input  data_t                   bias,
    output data_t                   result
);

    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(Q_MAX);
    localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(Q_MIN);

    function automatic data_t sat_clamp(input logic signed [ACC_W:0] v);
        data_t r;
        if (v > SAT_HI) begin
            r = Q_MAX;
        end else if (v < SAT_LO) begin
            r = Q_MIN;
        end else begin
            r = data_t'(v);
        end
        return r;
    endfunction

    function automatic data_t activate(input data_t v);
        data_t r;
        r = v;
`ifdef NEURON_MAC_RELU_EN
        if (v < 0) begin
            r = '0;
        end
`endif
        return r;
    endfunction

    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W:0]   sum;

    // Shift floors toward -inf; one extra bit keeps the bias add from wrapping.
    assign shifted = acc >>> FRAC_BITS;
    assign sum     = (ACC_W+1)'(shifted) + (ACC_W+1)'(bias);
    assign result  = activate(sat_clamp(sum));

endmodule

// File: rtl/neuron_mac.sv
// Single-neuron Q8.8 multiply-accumulate: streams N_INPUTS (x, w) pairs, adds
// bias, rescales and saturates. ReLU output selectable via NEURON_MAC_RELU_EN.
module neuron_mac
    import ann_pkg::*;
#(
    parameter int N_INPUTS  = 4,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start,
    input  data_t bias,
    input  data_t x,
    input  data_t w,
    input  logic  in_valid,
    output logic  in_ready,
    output logic  busy,
    output logic  out_clr,
    output logic  out_valid,
    output data_t out_data
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    data_t                   bias_q;
    logic signed [31:0]      prod;
    data_t                   sat_result;

    assign in_ready = (state == ACC);
    assign busy     = (state != IDLE);
    assign prod     = 32'(x) * 32'(w);

    ann_saturate #(
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_sat (
        .acc    (acc),
        .bias   (bias_q),
        .result (sat_result)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            bias_q    <= '0;
            out_clr   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_clr   <= 1'b0;
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bias_q  <= bias;
                        acc     <= '0;
                        cnt     <= '0;
                        out_clr <= 1'b1;
                        state   <= ACC;
                    end
                end
                // Accumulate stage: only accepted beats touch acc/cnt.
                ACC: begin
                    if (in_valid) begin
                        acc <= acc + ACC_W'(prod);
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            state <= FINISH;
                        end
                    end
                end
                // Output stage: register the saturated result for one cycle.
                FINISH: begin
                    out_data  <= sat_result;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
